// File: rtl/ue_pkg.sv
// Shared opcode constants and default widths for the micro-engine blocks.
package ue_pkg;

    localparam int unsigned UE_ADDR_W   = 4;
    localparam int unsigned UE_RS_DEPTH = 4;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP0 = 4'h0;
    localparam opcode_t OP_NOP1 = 4'h1;
    localparam opcode_t OP_NOP2 = 4'h2;
    localparam opcode_t OP_NOP3 = 4'h3;
    localparam opcode_t OP_NOP4 = 4'h4;
    localparam opcode_t OP_NOP5 = 4'h5;
    localparam opcode_t OP_NOP6 = 4'h6;
    localparam opcode_t OP_NOP7 = 4'h7;
    localparam opcode_t OP_NOP8 = 4'h8;
    localparam opcode_t OP_NOP9 = 4'h9;
    localparam opcode_t OP_NOPA = 4'hA;
    localparam opcode_t OP_NOPB = 4'hB;
    localparam opcode_t OP_NOPC = 4'hC;
    localparam opcode_t OP_NOPD = 4'hD;
    localparam opcode_t OP_NOPE = 4'hE;
    localparam opcode_t OP_NOPF = 4'hF;

endpackage

// File: rtl/ue_retstack.sv
// Return-address storage for the fetch sequencer.
// UE_SEQ_RETSTACK_EN selects an RS_DEPTH-entry circular LIFO; otherwise a single return register.
module ue_retstack
    import ue_pkg::*;
#(
    parameter int unsigned ADDR_W   = UE_ADDR_W,
    parameter int unsigned RS_DEPTH = UE_RS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr
);

`ifdef UE_SEQ_RETSTACK_EN
    localparam int unsigned PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

    logic [ADDR_W-1:0] ent_q [RS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              full;
    logic              empty;

    always_comb begin
        top_ptr = (wr_ptr_q == '0) ? PTR_W'(RS_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
        full    = (cnt_q == CNT_W'(RS_DEPTH));
        empty   = (cnt_q == '0);
    end

    // Popping an empty stack yields address 0.
    assign pop_addr = empty ? '0 : ent_q[top_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push) begin
            // When full the write slot is the oldest entry, so it is overwritten.
            ent_q[wr_ptr_q] <= push_addr;
            wr_ptr_q        <= (wr_ptr_q == PTR_W'(RS_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_q <= top_ptr;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_depth = RS_DEPTH;

    logic [ADDR_W-1:0] ret_q;
    logic              unused_pop;

    // A pop reads the register without consuming it.
    assign unused_pop = pop;
    assign pop_addr   = ret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q <= '0;
        end else if (push) begin
            ret_q <= push_addr;
        end
    end
`endif

endmodule

// File: rtl/ue_fetch_seq.sv
// Instruction fetch sequencer: flop program memory, zero-bubble JMP/RTN, sticky halt.
// Define UE_SEQ_RETSTACK_EN for a multi-entry return stack.
module ue_fetch_seq
    import ue_pkg::*;
#(
    parameter int unsigned ADDR_W   = UE_ADDR_W,
    parameter int unsigned RS_DEPTH = UE_RS_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [4+ADDR_W-1:0] prog_data,
    input  logic                core_jmp,
    input  logic                core_rtn,
    input  logic                core_flagf,
    output logic [3:0]          instr,
    output logic [ADDR_W-1:0]   operand,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);

    localparam int unsigned WORD_W    = 4 + ADDR_W;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    logic [3:0]        instr_q;
    logic [ADDR_W-1:0] operand_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;

    logic              do_halt;
    logic              fetch_en;
    logic              take_jmp;
    logic              take_rtn;
    logic [ADDR_W-1:0] rtn_addr;
    logic [ADDR_W-1:0] fetch_addr;

    // Core flags only mean something while a fetched word is being presented.
    always_comb begin
        do_halt    = valid_q && core_flagf;
        fetch_en   = run && !halted_q && !do_halt;
        take_jmp   = fetch_en && valid_q && core_jmp;
        take_rtn   = fetch_en && valid_q && core_rtn && !core_jmp;
        fetch_addr = pc_q;
        if (take_jmp) begin
            fetch_addr = operand_q;
        end else if (take_rtn) begin
            fetch_addr = rtn_addr;
        end
    end

    ue_retstack #(
        .ADDR_W   (ADDR_W),
        .RS_DEPTH (RS_DEPTH)
    ) u_retstack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (take_jmp),
        .pop       (take_rtn),
        .push_addr (pc_q),
        .pop_addr  (rtn_addr)
    );

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= OP_NOP0;
            operand_q <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            halted_q  <= 1'b0;
        end else if (do_halt) begin
            halted_q <= 1'b1;
            instr_q  <= OP_NOP0;
            valid_q  <= 1'b0;
        end else if (fetch_en) begin
            {instr_q, operand_q} <= mem[fetch_addr];
            valid_q              <= 1'b1;
            pc_q                 <= fetch_addr + ADDR_W'(1);
        end else begin
            instr_q <= OP_NOP0;
            valid_q <= 1'b0;
        end
    end

    assign instr       = instr_q;
    assign operand     = operand_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_ue_fetch_seq.sv
// Self-checking bench for ue_fetch_seq: directed vector table, corner sequences, random vs model.
module tb_ue_fetch_seq;
    import ue_pkg::*;

    localparam int unsigned AW  = 4;
    localparam int unsigned RSD = 4;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [AW+3:0] prog_data;
    logic          core_jmp;
    logic          core_rtn;
    logic          core_flagf;
    logic [3:0]    instr;
    logic [AW-1:0] operand;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;

    ue_fetch_seq #(
        .ADDR_W   (AW),
        .RS_DEPTH (RSD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .core_jmp    (core_jmp),
        .core_rtn    (core_rtn),
        .core_flagf  (core_flagf),
        .instr       (instr),
        .operand     (operand),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW+3:0] m_mem [16];
    logic [3:0]    m_instr;
    logic [AW-1:0] m_operand;
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic          m_halted;
    logic [AW-1:0] m_stack [$];
    logic [AW-1:0] m_ret;

    typedef struct {
        logic       run;
        logic       jmp;
        logic       rtn;
        logic [3:0] e_instr;
        logic [3:0] e_pc;
        logic       e_valid;
    } vec_t;

    task automatic model_reset();
        m_instr   = 4'h0;
        m_operand = '0;
        m_valid   = 1'b0;
        m_pc      = '0;
        m_halted  = 1'b0;
        m_stack.delete();
        m_ret     = '0;
    endtask

    task automatic model_edge();
        logic [AW-1:0] fa;
        logic [AW+3:0] w;
        if (m_valid && core_flagf) begin
            m_halted = 1'b1;
            m_instr  = 4'h0;
            m_valid  = 1'b0;
        end else if (m_halted || !run) begin
            m_instr = 4'h0;
            m_valid = 1'b0;
        end else begin
            fa = m_pc;
            if (m_valid && core_jmp) begin
                fa = m_operand;
`ifdef UE_SEQ_RETSTACK_EN
                m_stack.push_back(m_pc);
                if (m_stack.size() > RSD) void'(m_stack.pop_front());
`else
                m_ret = m_pc;
`endif
            end else if (m_valid && core_rtn) begin
`ifdef UE_SEQ_RETSTACK_EN
                fa = (m_stack.size() == 0) ? '0 : m_stack.pop_back();
`else
                fa = m_ret;
`endif
            end
            w         = m_mem[fa];
            m_instr   = w[AW+3:AW];
            m_operand = w[AW-1:0];
            m_valid   = 1'b1;
            m_pc      = AW'((int'(fa) + 1) % 16);
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
    endtask

    task automatic check_model(input string name);
        checks++;
        if (instr !== m_instr || operand !== m_operand || instr_valid !== m_valid ||
            pc !== m_pc || halted !== m_halted) begin
            errors++;
            $display("FAIL %s: got instr=%h operand=%h valid=%b pc=%h halted=%b, want instr=%h operand=%h valid=%b pc=%h halted=%b",
                     name, instr, operand, instr_valid, pc, halted,
                     m_instr, m_operand, m_valid, m_pc, m_halted);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_in(input logic r, input logic j, input logic t, input logic f);
        run        = r;
        core_jmp   = j;
        core_rtn   = t;
        core_flagf = f;
    endtask

    task automatic tick(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        prog_we = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_model("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [AW+3:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick("load");
        prog_we = 1'b0;
    endtask

    vec_t tab [12];
    logic [AW-1:0] pc_hold;
    logic [3:0]    nest_pc [10];

    initial begin
        rst_n = 1'b1;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 'x;

        // Reset values from constants
        rst_n = 1'b0;
        #1;
        check_val("rst_pc", {4'h0, pc}, 8'h00);
        check_val("rst_instr", {instr, operand}, 8'h00);
        check_val("rst_flags", {6'h0, instr_valid, halted}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) write_word(AW'(i), 8'($urandom));
        write_word(4'd0, {OP_NOP1, 4'd1});
        write_word(4'd1, {OP_NOP4, 4'd0});
        write_word(4'd2, {OP_NOP8, 4'd2});
        write_word(4'd3, {OP_NOP6, 4'd3});
        write_word(4'd4, {OP_NOP7, 4'd0});
        write_word(4'd5, {OP_NOPC, 4'd9});
        write_word(4'd6, {OP_NOP3, 4'd1});
        write_word(4'd7, {OP_NOP5, 4'd5});
        write_word(4'd9, {OP_NOP2, 4'd7});

        tab[0]  = '{1'b1, 1'b0, 1'b0, OP_NOP1, 4'd1, 1'b1};
        tab[1]  = '{1'b1, 1'b0, 1'b0, OP_NOP4, 4'd2, 1'b1};
        tab[2]  = '{1'b1, 1'b0, 1'b0, OP_NOP8, 4'd3, 1'b1};
        tab[3]  = '{1'b1, 1'b0, 1'b0, OP_NOP6, 4'd4, 1'b1};
        tab[4]  = '{1'b1, 1'b0, 1'b0, OP_NOP7, 4'd5, 1'b1};
        tab[5]  = '{1'b1, 1'b0, 1'b0, OP_NOPC, 4'd6, 1'b1};
        tab[6]  = '{1'b1, 1'b1, 1'b0, OP_NOP2, 4'd10, 1'b1};
        tab[7]  = '{1'b1, 1'b0, 1'b1, OP_NOP3, 4'd7, 1'b1};
        tab[8]  = '{1'b0, 1'b0, 1'b0, OP_NOP0, 4'd7, 1'b0};
        tab[9]  = '{1'b0, 1'b0, 1'b0, OP_NOP0, 4'd7, 1'b0};
        tab[10] = '{1'b0, 1'b0, 1'b0, OP_NOP0, 4'd7, 1'b0};
        tab[11] = '{1'b1, 1'b0, 1'b0, OP_NOP5, 4'd8, 1'b1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tab[i].run, tab[i].jmp, tab[i].rtn, 1'b0);
            tick("table_model");
            check_val($sformatf("table%0d", i), {instr, pc},
                      {tab[i].e_instr, tab[i].e_pc});
            check_val($sformatf("table%0d_valid", i), {7'h0, instr_valid},
                      {7'h0, tab[i].e_valid});
        end

        // Walk to the top address and wrap
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && pc != 4'hF; i++) tick("walk");
        check_val("reached_top", {4'h0, pc}, 8'h0F);
        tick("wrap");
        check_val("wrap_pc", {4'h0, pc}, 8'h00);

        // Sticky halt, pc frozen, writes still accepted
        tick("pre_halt");
        pc_hold = pc;
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        tick("halt");
        check_val("halt_flags", {6'h0, halted, instr_valid}, 8'h02);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("halted_run");
        check_val("halt_pc_frozen", {4'h0, pc}, {4'h0, pc_hold});
        write_word(4'd0, {OP_NOPB, 4'd4});
        check_val("halt_still", {7'h0, halted}, 8'h01);
        do_reset();
        check_val("halt_cleared", {7'h0, halted}, 8'h00);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick("after_halt");
        check_val("halt_write_seen", {instr, pc}, {OP_NOPB, 4'd1});

        // Reset asserted alongside a jump
        tick("pre_rst_jmp");
        core_jmp = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_jmp_pc", {4'h0, pc}, 8'h00);
        check_model("rst_jmp_state");
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick("rst_jmp_first");
        check_val("rst_jmp_fetch0", {instr, pc}, {OP_NOPB, 4'd1});

        // Five nested jumps then five returns
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        write_word(4'd0, {OP_NOPC, 4'd2});
        write_word(4'd2, {OP_NOPC, 4'd4});
        write_word(4'd4, {OP_NOPC, 4'd6});
        write_word(4'd6, {OP_NOPC, 4'd8});
        write_word(4'd8, {OP_NOPC, 4'd10});
        write_word(4'd10, {OP_NOPD, 4'd0});
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick("nest_start");
        nest_pc[0] = 4'd3; nest_pc[1] = 4'd5; nest_pc[2] = 4'd7;
        nest_pc[3] = 4'd9; nest_pc[4] = 4'd11;
`ifdef UE_SEQ_RETSTACK_EN
        nest_pc[5] = 4'd10; nest_pc[6] = 4'd8; nest_pc[7] = 4'd6;
        nest_pc[8] = 4'd4;  nest_pc[9] = 4'd1;
`else
        nest_pc[5] = 4'd10; nest_pc[6] = 4'd10; nest_pc[7] = 4'd10;
        nest_pc[8] = 4'd10; nest_pc[9] = 4'd10;
`endif
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, i < 5, i >= 5, 1'b0);
            tick("nest_model");
            check_val($sformatf("nest%0d_pc", i), {4'h0, pc}, {4'h0, nest_pc[i]});
        end

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (m_halted && ($urandom % 4 == 0)) do_reset();
            prog_we   = ($urandom % 8 == 0);
            prog_addr = AW'($urandom);
            prog_data = 8'($urandom);
            run        = ($urandom % 8 != 0);
            core_jmp   = ($urandom % 5 == 0);
            core_rtn   = ($urandom % 5 == 0);
            core_flagf = run && !core_jmp && !core_rtn && ($urandom % 40 == 0);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ue_fetch_seq.md
UE_FETCH_SEQ -- requirements
Module: ue_fetch_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: program-address width; program depth is 2**ADDR_W words.
REQ-002 SHALL have parameter RS_DEPTH, default 4: return-stack depth, used only when UE_SEQ_RETSTACK_EN is defined.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  fetch enable.
REQ-006 SHALL have port prog_we  input  1  program-memory write strobe.
REQ-007 SHALL have port prog_addr  input  ADDR_W  program write address.
REQ-008 SHALL have port prog_data  input  4+ADDR_W  program word, {opcode[3:0], operand[ADDR_W-1:0]}.
REQ-009 SHALL have port core_jmp  input  1  JMP flag from the core for the instruction currently presented.
REQ-010 SHALL have port core_rtn  input  1  RTN flag from the core for the instruction currently presented.
REQ-011 SHALL have port core_flagf  input  1  NOPF flag from the core; requests halt.
REQ-012 SHALL have port instr  output  4  opcode presented to the core.
REQ-013 SHALL have port operand  output  ADDR_W  operand field; selects the I/O bit and supplies the jump target.
REQ-014 SHALL have port instr_valid  output  1  high when instr/operand hold a fetched word.
REQ-015 SHALL have port pc  output  ADDR_W  address of the next word to fetch.
REQ-016 SHALL have port halted  output  1  sticky halt indicator.

Function
REQ-017 SHALL hold the program memory in flops: a write when prog_we is high at an edge takes effect at that edge, and a same-edge fetch from that address returns the old word.
REQ-018 SHALL, at each edge with run=1 and halted=0, register {instr, operand} <= mem[fetch_addr], set instr_valid <= 1, and set pc <= fetch_addr+1, wrapping modulo 2**ADDR_W.
REQ-019 SHALL use fetch_addr = operand when core_jmp=1 and instr_valid=1, so a jump costs zero bubble cycles.
REQ-020 SHALL, on a taken JMP, push the return address, which is the current pc (the word after the JMP).
REQ-021 SHALL use fetch_addr = popped return address when core_rtn=1, core_jmp=0 and instr_valid=1.
REQ-022 SHALL use fetch_addr = pc in all other fetch cycles.
REQ-023 SHALL give core_jmp priority over core_rtn when both are high, with no pop.
REQ-024 SHALL ignore core_jmp, core_rtn and core_flagf while instr_valid=0.
REQ-025 SHALL, at an edge with run=0, hold pc and the stack, set instr <= 4'b0000 (NOP0), and set instr_valid <= 0.
REQ-026 SHALL, at an edge with core_flagf=1 and instr_valid=1, set halted <= 1, instr <= NOP0, and instr_valid <= 0, leaving pc unchanged.
REQ-027 SHALL exit halt only through reset.
REQ-028 SHALL keep accepting program writes while halted or while run=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately force pc=0, instr=0, operand=0, instr_valid=0, halted=0, all return entries to 0, and the stack pointer to empty.
REQ-030 SHALL NOT reset the program memory contents.
REQ-031 SHALL abandon any in-flight jump or return when reset is asserted mid-operation; the first fetch after release is from address 0.

Configuration
REQ-032 SHALL, with UE_SEQ_RETSTACK_EN defined, implement an RS_DEPTH-entry LIFO return stack.
REQ-033 SHALL, with UE_SEQ_RETSTACK_EN defined, overwrite the oldest entry on a push when the stack is full (circular pointer).
REQ-034 SHALL, with UE_SEQ_RETSTACK_EN defined, return to address 0 on a pop when the stack is empty and leave the pointer at empty.
REQ-035 SHALL, without UE_SEQ_RETSTACK_EN, implement a single return register: each push overwrites it, and a pop reads it without clearing it.

Structure
REQ-036 SHALL take the opcode constants OP_NOP0..OP_NOPF (4'h0..4'hF) and the default widths from the shared package ue_pkg.
REQ-037 SHALL place the return storage in one sub-module, ue_retstack, whose contents are selected by UE_SEQ_RETSTACK_EN.

Verification
REQ-038 SHALL cover: load mem[0..3]={LD 1, ONE 0, STO 2, OR 3}, run=1 -> instr sequence 1,4,8,6 on consecutive edges, with pc 1,2,3,4.
REQ-039 SHALL cover: JMP with operand 9 at address 5, core_jmp pulsed -> next word comes from mem[9], pc=10; then RTN -> next word comes from mem[6].
REQ-040 SHALL cover: with UE_SEQ_RETSTACK_EN, five nested JMPs followed by five RTNs -> four correct returns, then a fetch from address 0.
REQ-041 SHALL cover: core_flagf pulsed -> halted=1 and instr_valid=0 from the next edge, and pc frozen despite run=1 until rst_n pulses low.
REQ-042 SHALL cover: pc at 2**ADDR_W-1 -> wraps to 0; run dropped for 3 cycles -> pc held and instr=0.
REQ-043 SHALL cover: rst_n asserted in the same cycle as core_jmp -> pc=0 immediately, and the first fetch after release is from mem[0].
